decoder_3to8_sync: RTL and testbench
====================================

Name: decoder_3to8_sync

Overview:
Registered 3-to-8 line decoder. Converts a 3-bit binary select into a one-hot 8-bit output, captured on the clock edge. Used wherever a binary index must drive one of eight enables, e.g. register-bank write strobes or mux selects. Contains a combinational one-hot core followed by an output register with synchronous clear.

Parameters:
- ACTIVE_LOW, default 0: 0 = selected output bit is 1 and the others are 0; 1 = the bitwise inverse (selected bit 0, others 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en   input  1  decode enable; sampled at the rising edge of clk
- s    input  3  binary select; s[2] is the MSB
- d    output 8  registered one-hot decode; d[i] corresponds to s == i
- valid  output 1  registered; 1 when d holds a decode of an enabled select

Behaviour:
- All state updates occur on the rising edge of clk only. There are no asynchronous paths.
- Reset: when rst = 1 at an edge, d <= idle pattern and valid <= 0.
  - Idle pattern is 8'h00 when ACTIVE_LOW = 0 and 8'hFF when ACTIVE_LOW = 1.
  - rst has priority over en and s.
- Decode: when rst = 0 and en = 1 at an edge:
  - d <= (8'h01 << s), inverted if ACTIVE_LOW = 1.
  - valid <= 1.
- Disable: when rst = 0 and en = 0 at an edge, d <= idle pattern and valid <= 0. The output does not hold its last decode.
- Latency: exactly 1 cycle from sampled (en, s) to d and valid.
  - Back-to-back enabled cycles each produce an updated output every cycle.
  - No bubbles and no handshake.
- Mapping (ACTIVE_LOW = 0):
  - s = 0 -> 8'h01, s = 1 -> 8'h02, s = 2 -> 8'h04, s = 3 -> 8'h08
  - s = 4 -> 8'h10, s = 5 -> 8'h20, s = 6 -> 8'h40, s = 7 -> 8'h80
- Invariants:
  - Exactly one bit of d is active whenever valid = 1.
  - No bit of d is active whenever valid = 0.
- Boundaries:
  - s = 7 drives d[7]; there is no wrap and no out-of-range case, since all 8 codes are legal.
  - Reset asserted mid-stream clears d on that same edge. The first enabled edge after reset deasserts produces a valid decode.
- Power-up: outputs are undefined until the first reset edge. The bench must apply rst before checking.
- s and en are assumed stable around the clock edge; no internal synchronisation is provided.

Decomposition:
- Shared package decoder_pkg holds:
  - SEL_W = 3
  - OUT_W = 8 (= 2**SEL_W)
  - function onehot_idle(active_low), returning the idle pattern
- Sub-module decoder_3to8_core is purely combinational:
  - Inputs s[2:0]; output onehot[7:0] = 1 << s.
  - Implemented as an explicit 8-way case.
- The top level owns the register, the enable/reset priority and the ACTIVE_LOW inversion.

Test Plan:
1. Reset: hold rst = 1 for 2 cycles with en = 1 and s = 5 -> d = 8'h00 and valid = 0 on every edge while rst is high.
2. Truth-table sweep: rst = 0, en = 1, apply s = 0..7 holding each for several cycles -> one cycle after each change, d = 8'h01, 02, 04, 08, 10, 20, 40, 80 and valid = 1.
3. Back-to-back: change s every cycle in the order 7, 0, 3, 4 -> d = 80, 01, 08, 10 on consecutive edges, each one cycle late.
4. Enable gating: en = 1 with s = 2, then en = 0 -> d = 8'h04, then 8'h00 with valid = 0 on the next edge. Changing s while en = 0 has no effect on d.
5. Reset mid-stream: en = 1 with s = 6 steady; pulse rst = 1 for 1 cycle -> sequence d = 40, 00, 40 with valid = 1, 0, 1.
6. ACTIVE_LOW = 1 instance: after reset d = 8'hFF; s = 0 gives 8'hFE and s = 7 gives 8'h7F; en = 0 returns d to 8'hFF.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths and idle-pattern helper for the 3-to-8 decoder
package decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 2 ** SEL_W;

    // Pattern driven on d whenever no decode is being presented
    function automatic logic [OUT_W-1:0] onehot_idle(input logic active_low);
        return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// rtl/decoder_3to8_core.sv - combinational binary-to-one-hot core
module decoder_3to8_core
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0] s,
    output logic [OUT_W-1:0] onehot
);

    // Explicit 8-way decode; every select code is legal
    always_comb begin
        onehot = '0;
        case (s)
            3'd0:    onehot = 8'h01;
            3'd1:    onehot = 8'h02;
            3'd2:    onehot = 8'h04;
            3'd3:    onehot = 8'h08;
            3'd4:    onehot = 8'h10;
            3'd5:    onehot = 8'h20;
            3'd6:    onehot = 8'h40;
            3'd7:    onehot = 8'h80;
            default: onehot = '0;
        endcase
    end

endmodule

// File: rtl/decoder_3to8_sync.sv
// rtl/decoder_3to8_sync.sv - registered 3-to-8 decoder with enable, sync clear and polarity select
module decoder_3to8_sync
    import decoder_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] s,
    output logic [OUT_W-1:0] d,
    output logic             valid
);

    localparam logic [OUT_W-1:0] IDLE = onehot_idle(ACTIVE_LOW);

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] d_d;
    logic [OUT_W-1:0] d_q;
    logic             valid_d;
    logic             valid_q;

    decoder_3to8_core u_core (
        .s      (s),
        .onehot (onehot)
    );

    // Next output: reset beats enable; a disabled cycle falls back to idle rather than holding
    always_comb begin
        d_d     = IDLE;
        valid_d = 1'b0;
        if (!rst && en) begin
            d_d     = ACTIVE_LOW ? ~onehot : onehot;
            valid_d = 1'b1;
        end
    end

    // Output register; rst is folded into d_d/valid_d so the flop is a plain capture
    always_ff @(posedge clk) begin
        d_q     <= d_d;
        valid_q <= valid_d;
    end

    assign d     = d_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_3to8_sync.sv
// tb/tb_decoder_3to8_sync.sv - self-checking bench for both polarities of decoder_3to8_sync
module tb_decoder_3to8_sync;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] s;
    logic [7:0] d_hi;
    logic       valid_hi;
    logic [7:0] d_lo;
    logic       valid_lo;

    int vectors;
    int miscompares;

    decoder_3to8_sync #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .s     (s),
        .d     (d_hi),
        .valid (valid_hi)
    );

    decoder_3to8_sync #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .s     (s),
        .d     (d_lo),
        .valid (valid_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector, let one edge pass, and compare both instances to the reference
    task automatic apply(input logic r, input logic e, input logic [2:0] sel, input string tag);
        int unsigned weight;
        logic        exp_valid;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        rst = r;
        en  = e;
        s   = sel;
        @(posedge clk);
        #1;
        weight    = 2 ** int'(sel);
        exp_valid = !r && e;
        exp_hi    = exp_valid ? 8'(weight) : 8'h00;
        exp_lo    = exp_valid ? 8'(255 - weight) : 8'hFF;
        vectors++;
        assert (d_hi === exp_hi) else begin
            miscompares++;
            $error("FAIL %s d(hi) s=%0d: got %h expected %h", tag, sel, d_hi, exp_hi);
        end
        assert (valid_hi === exp_valid) else begin
            miscompares++;
            $error("FAIL %s valid(hi) s=%0d: got %b expected %b", tag, sel, valid_hi, exp_valid);
        end
        assert (d_lo === exp_lo) else begin
            miscompares++;
            $error("FAIL %s d(lo) s=%0d: got %h expected %h", tag, sel, d_lo, exp_lo);
        end
        assert (valid_lo === exp_valid) else begin
            miscompares++;
            $error("FAIL %s valid(lo) s=%0d: got %b expected %b", tag, sel, valid_lo, exp_valid);
        end
        assert ($countones(d_hi) === (exp_valid ? 1 : 0)) else begin
            miscompares++;
            $error("FAIL %s onehot-count: got %0d expected %0d", tag, $countones(d_hi), exp_valid ? 1 : 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b1;
        s   = 3'd5;

        // Reset held two cycles with en high and s = 5
        apply(1'b1, 1'b1, 3'd5, "reset");
        apply(1'b1, 1'b1, 3'd5, "reset");

        // Truth-table sweep, each select held several cycles
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                apply(1'b0, 1'b1, 3'(i), "sweep");
            end
        end

        // Back-to-back changes every cycle
        apply(1'b0, 1'b1, 3'd7, "b2b");
        apply(1'b0, 1'b1, 3'd0, "b2b");
        apply(1'b0, 1'b1, 3'd3, "b2b");
        apply(1'b0, 1'b1, 3'd4, "b2b");

        // Enable gating; s changes while disabled must not show
        apply(1'b0, 1'b1, 3'd2, "gate");
        apply(1'b0, 1'b0, 3'd2, "gate");
        apply(1'b0, 1'b0, 3'd5, "gate");
        apply(1'b0, 1'b0, 3'd7, "gate");
        apply(1'b0, 1'b1, 3'd7, "gate");

        // Reset pulse in the middle of a steady stream
        apply(1'b0, 1'b1, 3'd6, "midrst");
        apply(1'b1, 1'b1, 3'd6, "midrst");
        apply(1'b0, 1'b1, 3'd6, "midrst");

        // Randomised traffic with occasional reset and disable
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
